// File: rtl/spi_rx_capture.sv
// Receive capture stage behind the SPI slave: synchronizes the slave's done
// flag, captures one word per frame into a FWFT FIFO, and exposes valid/ready.
module spi_rx_capture #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       slv_done,
   input  logic [WIDTH-1:0]           slv_dout,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic                       overflow,
   output logic [CNT_W-1:0]           frame_cnt,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic             s1, s2, s3;
   logic             push_req;
   logic             pop;
   logic             full;
   logic             wr_en;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Only s1 touches the asynchronous flag; s2/s3 form the edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= slv_done;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign push_req = s2 & ~s3;
   assign m_valid  = (level != '0);
   assign pop      = m_valid & m_ready;
   assign full     = (level == LW'(DEPTH));
   assign wr_en    = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (push_req)
            frame_cnt <= frame_cnt + CNT_W'(1);
         if (push_req & full & ~pop)
            overflow <= 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en & ~pop)
            level <= level + LW'(1);
         else if (pop & ~wr_en)
            level <= level - LW'(1);
      end
   end

   // NOTE: storage is deliberately left out of reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= slv_dout;
   end

   assign m_data = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_spi_rx_capture.sv
// Self-checking bench for spi_rx_capture: a queue-based model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_spi_rx_capture;

   localparam int DEPTH = 4;
   localparam int WIDTH = 12;
   localparam int CNT_W = 4;
   localparam int LW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             slv_done = 1'b0;
   logic [WIDTH-1:0] slv_dout = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic             overflow;
   logic [CNT_W-1:0] frame_cnt;
   logic [LW-1:0]    level;

   int n_vec = 0;
   int n_err = 0;

   spi_rx_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .slv_done  (slv_done),
      .slv_dout  (slv_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .overflow  (overflow),
      .frame_cnt (frame_cnt),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame lands in the queue on the third clock edge after the
   // bench raises done; the consumer takes the head whenever ready is high.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] pend_word = '0;
   int               pend = 0;
   int               m_cnt = 0;
   bit               m_ovf = 1'b0;
   bit               model_ok = 1'b0;

   always @(posedge clk) begin
      bit do_pop, do_push;
      if (rst) begin
         q.delete();
         m_ovf    = 1'b0;
         m_cnt    = 0;
         pend     = 0;
         model_ok = 1'b1;
      end else begin
         do_pop  = (q.size() != 0) && m_ready;
         do_push = (pend == 1);
         if (pend > 0) pend--;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (q.size() < DEPTH) q.push_back(pend_word);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("m_valid",   32'(m_valid),   32'(q.size() != 0));
         check("m_data",    32'(m_data),    (q.size() != 0) ? 32'(q[0]) : 32'h0);
         check("level",     32'(level),     32'(q.size()));
         check("overflow",  32'(overflow),  32'(m_ovf));
         check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      end
   end

   // Raise done for 'hold' cycles (>=3); optionally assert ready exactly at the push edge.
   task automatic frame(input logic [WIDTH-1:0] word, input int hold, input bit pop_at_push);
      slv_dout  = word;
      pend_word = word;
      slv_done  = 1'b1;
      pend      = 3;
      repeat (2) @(negedge clk);
      if (pop_at_push) begin
         m_ready = 1'b1;
         @(negedge clk);
         m_ready = 1'b0;
      end else begin
         @(negedge clk);
      end
      repeat (hold - 3) @(negedge clk);
      slv_done = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic expect_head(input logic [WIDTH-1:0] word);
      check("drain_valid", 32'(m_valid), 32'h1);
      check("drain_data",  32'(m_data),  32'(word));
      m_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic expect_empty();
      m_ready = 1'b0;
      check("empty_valid", 32'(m_valid), 32'h0);
      check("empty_data",  32'(m_data),  32'h0);
      check("empty_level", 32'(level),   32'h0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(m_valid),   32'h0);
      check("rst_data",  32'(m_data),    32'h0);
      check("rst_level", 32'(level),     32'h0);
      check("rst_ovf",   32'(overflow),  32'h0);
      check("rst_cnt",   32'(frame_cnt), 32'h0);

      // Single frame with a long done: visible exactly after the third edge.
      slv_dout  = 12'hA5C;
      pend_word = 12'hA5C;
      slv_done  = 1'b1;
      pend      = 3;
      @(negedge clk);
      check("lat_e0_valid", 32'(m_valid), 32'h0);
      @(negedge clk);
      check("lat_e1_valid", 32'(m_valid), 32'h0);
      @(negedge clk);
      check("lat_e2_valid", 32'(m_valid), 32'h1);
      check("single_data",  32'(m_data),  32'hA5C);
      check("single_level", 32'(level),   32'h1);
      check("single_cnt",   32'(frame_cnt), 32'h1);
      repeat (19) @(negedge clk);
      slv_done = 1'b0;
      repeat (6) @(negedge clk);
      check("single_once_level", 32'(level),     32'h1);
      check("single_once_cnt",   32'(frame_cnt), 32'h1);
      expect_head(12'hA5C);
      expect_empty();

      // Ordered drain, one pop per cycle.
      frame(12'h001, 4, 1'b0);
      frame(12'h002, 4, 1'b0);
      frame(12'h003, 4, 1'b0);
      check("order_level", 32'(level), 32'h3);
      expect_head(12'h001);
      expect_head(12'h002);
      expect_head(12'h003);
      expect_empty();

      // Overflow: fifth frame dropped, flag sticky through the drain.
      for (int i = 0; i < 5; i++) frame(12'h100 + 12'(i), 4, 1'b0);
      check("ovf_level", 32'(level),     32'h4);
      check("ovf_flag",  32'(overflow),  32'h1);
      check("ovf_cnt",   32'(frame_cnt), 32'h9);
      for (int i = 0; i < 4; i++) expect_head(12'h100 + 12'(i));
      expect_empty();
      check("ovf_sticky", 32'(overflow), 32'h1);

      // Reset with two words buffered and overflow set.
      frame(12'h010, 4, 1'b0);
      frame(12'h020, 4, 1'b0);
      check("pre_rst_level", 32'(level), 32'h2);
      pulse_reset();
      check("mid_rst_valid", 32'(m_valid),   32'h0);
      check("mid_rst_level", 32'(level),     32'h0);
      check("mid_rst_cnt",   32'(frame_cnt), 32'h0);
      check("mid_rst_ovf",   32'(overflow),  32'h0);
      frame(12'h7FF, 4, 1'b0);
      check("post_rst_data", 32'(m_data),    32'h7FF);
      check("post_rst_cnt",  32'(frame_cnt), 32'h1);
      expect_head(12'h7FF);
      expect_empty();

      // Push and pop in the same cycle while full.
      pulse_reset();
      for (int i = 0; i < 4; i++) frame(12'h100 + 12'(i), 4, 1'b0);
      check("full_level", 32'(level), 32'h4);
      frame(12'h200, 4, 1'b1);
      check("pp_level", 32'(level),    32'h4);
      check("pp_ovf",   32'(overflow), 32'h0);
      check("pp_head",  32'(m_data),   32'h101);
      expect_head(12'h101);
      expect_head(12'h102);
      expect_head(12'h103);
      expect_head(12'h200);
      expect_empty();

      // Counter wrap with a consumer that is always ready.
      pulse_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) frame(12'h300 + 12'(i), 4, 1'b0);
      m_ready = 1'b0;
      check("wrap_cnt",   32'(frame_cnt), 32'h1);
      check("wrap_ovf",   32'(overflow),  32'h0);
      check("wrap_level", 32'(level),     32'h0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_rx_capture.md
# spi_rx_capture

Receive-side capture stage that sits directly downstream of the SPI slave. It takes the slave's 12-bit parallel word and its `done` flag, which come from the `sclk` domain, and synchronizes `done` into the `clk` domain. On each completed frame it captures exactly one word. Captured words are buffered in a small first-word-fall-through FIFO and presented to the system on a valid/ready interface, with overflow and frame-count status.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `WIDTH`, default 12: frame word width; must match the slave word.
- `CNT_W`, default 16: width of the frame counter.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `slv_done`  in  1  slave frame-complete flag; asynchronous to `clk`; high for at least 3 `clk` cycles per frame.
- `slv_dout`  in  WIDTH  slave parallel word; stable from the rise of `slv_done` until the next frame starts shifting.
- `m_valid`  out  1  FIFO non-empty; head word available.
- `m_ready`  in  1  consumer accepts the head word.
- `m_data`  out  WIDTH  head word; 0 when empty.
- `overflow`  out  1  sticky flag: a frame was dropped because the FIFO was full.
- `frame_cnt`  out  CNT_W  count of frames detected, including dropped frames; wraps.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

## Operation
- **Synchronizer:** a 3-flop chain `s1` ← `slv_done`, `s2` ← `s1`, `s3` ← `s2`. Only `s1` may sample `slv_done`.
- **Frame event:** `push_req = s2 & ~s3`. This gives exactly one event per rising edge of `slv_done`, however long `done` stays high.
- **Capture:** on `push_req`, sample `slv_dout` directly. It is stable for many cycles, so no synchronizer is needed on the data bus.
- **Frame counter:** `frame_cnt` increments by 1 on every `push_req`, modulo 2^CNT_W. It counts regardless of FIFO state.
- **FIFO:** write pointer, read pointer, and an occupancy counter; pointers wrap modulo DEPTH.
  - Write when `push_req` and (`level` < DEPTH, or a pop occurs in the same cycle).
  - Pop when `m_valid & m_ready`.
- **Full, push without pop:** the word is dropped, `overflow` is set to 1, and FIFO contents and pointers are unchanged.
- **Full, push with pop:** the head is popped and the new word is written in the same cycle. `level` stays at DEPTH and no overflow occurs.
- **Empty, pop attempt:** when `m_ready`=1 while `m_valid`=0, nothing happens.
- **Outputs:**
  - `m_valid = (level != 0)`.
  - `m_data` = memory at the read pointer when `m_valid`, else 0.
- **`overflow`:** cleared only by `rst`.
- **Reset:**
  - `s1`/`s2`/`s3` = 0, pointers = 0, `level` = 0, `overflow` = 0, `frame_cnt` = 0.
  - Hence `m_valid` = 0 and `m_data` = 0.
  - FIFO memory contents need not be reset.
- **Reset mid-operation:** all buffered words are discarded. If `slv_done` is still high when `rst` deasserts, the frame is captured once after release. This is the required behaviour, because the slave word is complete and valid.

## Timing
- Let E0 be the first `clk` edge at which `s1` samples `slv_done`=1.
  - `s2`=1 after E1.
  - Push occurs at E2.
  - `m_valid`=1 and `level` are updated after E2.
  - Latency from `done` observed to data visible is 3 edges.
- `frame_cnt` updates at the same edge as the push. `overflow` rises at the edge of the dropped push.
- A pop at edge En frees its slot at En. `m_data` shows the next entry, or 0, after En.
- No combinational path from `m_ready` to `m_valid`. `m_data` is a combinational read of registered state only.
- `slv_done` pulses closer together than 3 `clk` cycles are outside the specification. In the system, an SPI frame lasts well over 200 `clk` cycles.

## Test plan
- **Single frame:** `slv_dout`=0xA5C, `slv_done` high for 22 cycles, `m_ready`=0 → `m_valid` rises exactly 3 edges after `done` is first sampled. `m_data`=0xA5C, `level`=1, `frame_cnt`=1, and only one entry is captured despite the long `done`.
- **Ordered drain:** frames 0x001, 0x002, 0x003, then `m_ready`=1 → words pop in order 0x001, 0x002, 0x003, one per cycle. `m_valid` falls after the third pop and `m_data`=0.
- **Overflow:** DEPTH=4, 5 frames 0x100..0x104 with `m_ready`=0 → `level`=4, `overflow`=1, `frame_cnt`=5. The FIFO holds 0x100..0x103 and 0x104 is lost. `overflow` stays 1 after the drain.
- **Simultaneous push/pop at full:** FIFO full (0x100..0x103), `m_ready`=1 in the same cycle as 0x200 is pushed → 0x100 is popped and 0x200 is accepted. `level` stays at 4, `overflow` stays 0, and the final drain order is 0x101, 0x102, 0x103, 0x200.
- **Reset mid-operation:** 2 words buffered, `rst` pulsed for 1 cycle while `slv_done`=0 → `m_valid`=0, `level`=0, `frame_cnt`=0, `overflow`=0. The next frame 0x7FF is captured normally.
- **Counter wrap:** CNT_W=4, 17 frames with `m_ready`=1 → `frame_cnt`=1 and the FIFO never overflows.
